line_burst_adapter: RTL and testbench

//   Bridges a cache-side, full-line memory port (addr/read/write/rdata/wdata/resp, one line per request)
//   to a banked burst memory port (addr/read/write/wdata/ready/raddr/rdata/rvalid).

---
 rtl/line_burst_pkg.sv | 25 ++
 rtl/line_burst_serdes.sv | 51 +++++
 rtl/line_burst_adapter.sv | 139 +++++++++++++
 tb/tb_line_burst_adapter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_burst_pkg.sv
// Shared types and helpers for the line-to-burst memory adapter.
package line_burst_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_REQ   = 3'd2,
    RD_WAIT  = 3'd3,
    RESP     = 3'd4
  } state_e;

  function automatic int unsigned burst_len(input int unsigned line_w, input int unsigned bus_w);
    return line_w / bus_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

  // Clear the byte-offset bits inside a line.
  function automatic logic [63:0] align_line(input logic [63:0] addr, input int unsigned off_w);
    return addr & ~((64'(1) << off_w) - 64'(1));
  endfunction

endpackage

// File: rtl/line_burst_serdes.sv
// Line buffer with beat counter: parallel load / shift out for writes, indexed beat insert for reads.
module line_burst_serdes
  import line_burst_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              clr,
  input  logic              shift,
  input  logic              insert,
  input  logic [BUS_W-1:0]  beat_in,
  output logic [BUS_W-1:0]  beat_out,
  output logic [LINE_W-1:0] merged_c,
  output logic              last_c
);

  localparam int unsigned BURST = burst_len(LINE_W, BUS_W);
  localparam int unsigned CNT_W = cnt_width(BURST);

  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  cnt_q;

  assign last_c   = (cnt_q == CNT_W'(BURST - 1));
  assign beat_out = line_q[BUS_W-1:0];

  // Buffer with the incoming beat dropped into the slot selected by the counter.
  always_comb begin
    merged_c = line_q;
    for (int unsigned i = 0; i < BURST; i++) begin
      if (cnt_q == CNT_W'(i)) merged_c[i*BUS_W +: BUS_W] = beat_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load || clr) begin
      if (load) line_q <= load_data;
      cnt_q <= '0;
    end else if (shift || insert) begin
      line_q <= shift ? (line_q >> BUS_W) : merged_c;
      cnt_q  <= last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/line_burst_adapter.sv
// Full-line cache port to banked burst memory bridge; all outputs registered.
// Define RAW_ADDR_CHECK_EN to flag stray or misaddressed read beats on the sticky err output.
module line_burst_adapter
  import line_burst_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BUS_W-1:0]  bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BUS_W-1:0]  bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              err
);

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);

  state_e            state_q, state_d;
  logic              resp_d, read_d, write_d, err_d;
  logic [ADDR_W-1:0] addr_d, aligned_c;
  logic [LINE_W-1:0] rdata_d, merged_c;
  logic              load, clr, shift, insert, last_c, raw_err_c;

  assign aligned_c = ADDR_W'(align_line(64'(line_addr), OFF_W));

`ifdef RAW_ADDR_CHECK_EN
  assign raw_err_c = bmem_rvalid && ((state_q != RD_WAIT) || (bmem_raddr != bmem_addr));
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign raw_err_c    = 1'b0;
`endif

  line_burst_serdes #(.LINE_W(LINE_W), .BUS_W(BUS_W)) u_serdes (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(line_wdata),
    .clr      (clr),
    .shift    (shift),
    .insert   (insert),
    .beat_in  (bmem_rdata),
    .beat_out (bmem_wdata),
    .merged_c (merged_c),
    .last_c   (last_c)
  );

  // Next state, next registered outputs and buffer controls.
  always_comb begin
    state_d = state_q;
    resp_d  = 1'b0;
    read_d  = bmem_read;
    write_d = bmem_write;
    addr_d  = bmem_addr;
    rdata_d = line_rdata;
    err_d   = err | raw_err_c;
    load    = 1'b0;
    clr     = 1'b0;
    shift   = 1'b0;
    insert  = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          state_d = WR_BURST;
          write_d = 1'b1;
          addr_d  = aligned_c;
          load    = 1'b1;
        end else if (line_read) begin
          state_d = RD_REQ;
          read_d  = 1'b1;
          addr_d  = aligned_c;
          clr     = 1'b1;
        end
      end
      WR_BURST: begin
        if (bmem_write && bmem_ready) begin
          shift = 1'b1;
          if (last_c) begin
            state_d = RESP;
            write_d = 1'b0;
            resp_d  = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (bmem_read && bmem_ready) begin
          state_d = RD_WAIT;
          read_d  = 1'b0;
        end
      end
      RD_WAIT: begin
        if (bmem_rvalid) begin
          insert = 1'b1;
          if (last_c) begin
            state_d = RESP;
            resp_d  = 1'b1;
            rdata_d = merged_c;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      line_resp  <= 1'b0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_addr  <= '0;
      line_rdata <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_resp  <= resp_d;
      bmem_read  <= read_d;
      bmem_write <= write_d;
      bmem_addr  <= addr_d;
      line_rdata <= rdata_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Bench for line_burst_adapter: directed vector table, reset abort sequence and randomized traffic.
`timescale 1ns/1ps
module tb_line_burst_adapter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned BUS_W  = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int          BURST  = LINE_W / BUS_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] line_addr = '0;
  logic              line_read = 1'b0;
  logic              line_write = 1'b0;
  logic [LINE_W-1:0] line_wdata = '0;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read, bmem_write;
  logic [BUS_W-1:0]  bmem_wdata;
  logic              bmem_ready = 1'b0;
  logic [ADDR_W-1:0] bmem_raddr = '0;
  logic [BUS_W-1:0]  bmem_rdata = '0;
  logic              bmem_rvalid = 1'b0;
  logic              err;

  int checks = 0;
  int failures = 0;
  logic [LINE_W-1:0] exp_rdata = '0;
  logic              exp_err = 1'b0;

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wd;
    logic [31:0]       rdy;
    int                gap;
    int                bad;
    logic [ADDR_W-1:0] exp_addr;
    int                exp_resp;
  } vec_t;

  vec_t vecs[6];

  line_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Completion cycle from the protocol rules: cycle 0 presents the request.
  function automatic int model_resp(input bit wr, input logic [31:0] m, input int gap);
    int n = 0;
    for (int c = 1; c < 200; c++) begin
      bit r = (c < 32) ? m[c] : 1'b1;
      if (r) begin
        if (!wr) return c + 1 + (BURST - 1) * (gap + 1) + 1;
        n++;
        if (n == BURST) return c + 1;
      end
    end
    return -1;
  endfunction

  // Presents one request and plays the memory side; starts and ends on an idle cycle.
  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd,
                         input logic [31:0] rdy, input int gap, input int bad, input bit noise,
                         input logic [ADDR_W-1:0] exp_addr, input int exp_resp);
    int resp_cyc = -1;
    int wbeat = 0;
    int rbeat = 0;
    int acc = -1;
    int next_rv = 0;
    logic [LINE_W-1:0] rline;
    for (int i = 0; i < LINE_W / 32; i++) rline[i*32 +: 32] = $urandom();
    line_addr = a; line_wdata = wd; line_write = wr; line_read = !wr;
    bmem_rvalid = 1'b0; bmem_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 200; c++) begin
      if (line_resp) begin
        resp_cyc = c;
        break;
      end
      chkw("bmem_addr", LINE_W'(bmem_addr), LINE_W'(exp_addr));
      chk1("bmem_write", bmem_write, wr);
      chk1("bmem_read", bmem_read, !wr && acc < 0);
      bmem_ready  = (c < 32) ? rdy[c] : 1'b1;
      bmem_rvalid = 1'b0;
      bmem_raddr  = exp_addr;
      bmem_rdata  = {$urandom(), $urandom()};
      if (!wr && acc >= 0 && rbeat < BURST && c >= next_rv) begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = rline[rbeat*BUS_W +: BUS_W];
        if (rbeat == bad) begin
          bmem_raddr = 32'h3000_0000;
`ifdef RAW_ADDR_CHECK_EN
          exp_err = 1'b1;
`endif
        end
        rbeat++;
        next_rv = c + gap + 1;
      end else if (wr && noise && $urandom_range(0, 3) == 0) begin
        bmem_rvalid = 1'b1;
`ifdef RAW_ADDR_CHECK_EN
        exp_err = 1'b1;
`endif
      end
      if (wr && bmem_write) begin
        chkw("bmem_wdata", LINE_W'(bmem_wdata), LINE_W'(wd[wbeat*BUS_W +: BUS_W]));
        if (bmem_ready) wbeat++;
      end
      if (!wr && bmem_read && bmem_ready && acc < 0) begin
        acc = c;
        next_rv = c + 1;
      end
      @(posedge clk); #1;
    end
    chki("resp_cycle", resp_cyc, exp_resp);
    if (!wr) exp_rdata = rline;
    chkw("line_rdata", line_rdata, exp_rdata);
    chk1("err", err, exp_err);
    chki("beats", wr ? wbeat : rbeat, BURST);
    line_write = 1'b0; line_read = 1'b0; bmem_rvalid = 1'b0;
    @(posedge clk); #1;
    chk1("resp_pulse", line_resp, 1'b0);
    chk1("idle_write", bmem_write, 1'b0);
  endtask

  logic [LINE_W-1:0] pat, rnd;
  logic [ADDR_W-1:0] ra;
  logic [31:0]       rm;
  bit                rw;
  int                rg, rb;

  initial begin
    for (int i = 0; i < LINE_W / 8; i++) pat[i*8 +: 8] = 8'(i + 1);
    for (int i = 0; i < LINE_W / 32; i++) rnd[i*32 +: 32] = $urandom();
    vecs[0] = '{1'b1, 32'h1000_0024, pat, 32'hFFFF_FFFF, 0, -1, 32'h1000_0020, 5};
    vecs[1] = '{1'b1, 32'h1000_0024, rnd, 32'hFFFF_FFF3, 0, -1, 32'h1000_0020, 7};
    vecs[2] = '{1'b0, 32'h2000_0040, '0,  32'hFFFF_FFF1, 2, -1, 32'h2000_0040, 15};
    vecs[3] = '{1'b1, 32'h0000_1234, pat, 32'hFFFF_FFFF, 0, -1, 32'h0000_1220, 5};
    vecs[4] = '{1'b0, 32'h0000_5678, '0,  32'hFFFF_FFFF, 0, -1, 32'h0000_5660, 6};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, '0,  32'hFFFF_FFFF, 1, -1, 32'hFFFF_FFE0, 9};

    // Reset values while held in reset.
    #2;
    chk1("rst_resp", line_resp, 1'b0);
    chk1("rst_read", bmem_read, 1'b0);
    chk1("rst_write", bmem_write, 1'b0);
    chk1("rst_err", err, 1'b0);
    chkw("rst_rdata", line_rdata, '0);
    chkw("rst_addr", LINE_W'(bmem_addr), '0);
    chkw("rst_wdata", LINE_W'(bmem_wdata), '0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Directed table; entries 3 and 4 run back to back.
    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wd, vecs[v].rdy, vecs[v].gap, vecs[v].bad, 1'b0,
              vecs[v].exp_addr, vecs[v].exp_resp);

    // Reset asserted during write beat 2 aborts the request.
    line_addr = 32'h0000_8000; line_wdata = pat; line_write = 1'b1; bmem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chkw("abort_beat2", LINE_W'(bmem_wdata), LINE_W'(pat[2*BUS_W +: BUS_W]));
    #2 rst = 1'b0;
    #1;
    chk1("abort_write", bmem_write, 1'b0);
    chk1("abort_resp", line_resp, 1'b0);
    chk1("abort_read", bmem_read, 1'b0);
    chk1("abort_err", err, 1'b0);
    chkw("abort_wdata", LINE_W'(bmem_wdata), '0);
    chkw("abort_addr", LINE_W'(bmem_addr), '0);
    chkw("abort_rdata", line_rdata, '0);
    line_write = 1'b0; exp_rdata = '0; exp_err = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; chk1("abort_no_resp", line_resp, 1'b0); end
    run_txn(1'b0, 32'h2000_0040, '0, 32'hFFFF_FFFF, 0, -1, 1'b0, 32'h2000_0040, 6);

    // Misaddressed beat 1; only flagged when the address check is built in.
    run_txn(1'b0, 32'h2000_0040, '0, 32'hFFFF_FFFF, 0, 1, 1'b0, 32'h2000_0040, 6);
    run_txn(1'b1, 32'h0000_0100, pat, 32'hFFFF_FFFF, 0, -1, 1'b0, 32'h0000_0100, 5);

    // Randomized traffic against the timing and data model.
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = $urandom();
      rm = $urandom();
      rg = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, 4)) - 1;
      for (int i = 0; i < LINE_W / 32; i++) rnd[i*32 +: 32] = $urandom();
      run_txn(rw, ra, rnd, rm, rg, rb, 1'b1, ra & ~32'h1F, model_resp(rw, rm, rg));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
